// File: rtl/button_debouncer.sv
// Per-lane debounce, press/auto-repeat increment strobes and a display refresh strobe.
// Each lane is an independent counter-based debouncer feeding a small repeat FSM.
module button_debouncer #(
  parameter int DIGITS         = 3,
  parameter int DB_CYCLES      = 10000,
  parameter int REPEAT_EN      = 1,
  parameter int REPEAT_DELAY   = 500000,
  parameter int REPEAT_RATE    = 100000,
  parameter int REFRESH_PERIOD = 50000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DIGITS-1:0] btn_in,
  output logic [DIGITS-1:0] btn_state,
  output logic [DIGITS-1:0] inc_pulse,
  output logic              refresh_req
);

  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int DB_W    = $clog2(DB_CYCLES);
  localparam int RPT_W   = $clog2(RPT_MAX);
  localparam int REF_W   = $clog2(REFRESH_PERIOD);

  typedef enum logic [1:0] {RELEASED, DELAY, REPEAT} lane_state_e;

  logic [DIGITS-1:0] inc_pulse_d;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_lane
      logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
      logic             btn_q, btn_d;
      lane_state_e      state_q, state_d;
      logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
      logic             inc_q, inc_d;

      always_comb begin
        db_cnt_d = db_cnt_q;
        btn_d    = btn_q;
        if (btn_in[gi] == btn_q) begin
          db_cnt_d = '0;
        end else if (db_cnt_q == DB_W'(DB_CYCLES - 1)) begin
          btn_d    = ~btn_q;
          db_cnt_d = '0;
        end else begin
          db_cnt_d = db_cnt_q + DB_W'(1);
        end
      end

      // The FSM looks at the registered level, so the press strobe lands one cycle after btn_state rises.
      always_comb begin
        state_d   = state_q;
        rpt_cnt_d = rpt_cnt_q;
        inc_d     = 1'b0;
        case (state_q)
          RELEASED: begin
            if (btn_q) begin
              inc_d     = 1'b1;
              rpt_cnt_d = '0;
              state_d   = (REPEAT_EN != 0) ? DELAY : REPEAT;
            end
          end
          DELAY: begin
            if (rpt_cnt_q == RPT_W'(REPEAT_DELAY - 1)) begin
              inc_d     = 1'b1;
              rpt_cnt_d = '0;
              state_d   = REPEAT;
            end else begin
              rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
            end
          end
          REPEAT: begin
            if (REPEAT_EN != 0) begin
              if (rpt_cnt_q == RPT_W'(REPEAT_RATE - 1)) begin
                inc_d     = 1'b1;
                rpt_cnt_d = '0;
              end else begin
                rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
              end
            end
          end
          default: state_d = RELEASED;
        endcase
        // Release wins over a coincident repeat terminal count.
        if (!btn_q) begin
          state_d   = RELEASED;
          rpt_cnt_d = '0;
          inc_d     = 1'b0;
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          db_cnt_q  <= '0;
          btn_q     <= 1'b0;
          state_q   <= RELEASED;
          rpt_cnt_q <= '0;
          inc_q     <= 1'b0;
        end else begin
          db_cnt_q  <= db_cnt_d;
          btn_q     <= btn_d;
          state_q   <= state_d;
          rpt_cnt_q <= rpt_cnt_d;
          inc_q     <= inc_d;
        end
      end

      assign inc_pulse_d[gi] = inc_d;
      assign btn_state[gi]   = btn_q;
      assign inc_pulse[gi]   = inc_q;
    end
  endgenerate

  logic [REF_W-1:0] ref_cnt_q, ref_cnt_d;
  logic             refresh_q, refresh_d;

  always_comb begin
    refresh_d = (|inc_pulse_d) || (ref_cnt_q == REF_W'(REFRESH_PERIOD - 1));
    ref_cnt_d = refresh_d ? '0 : ref_cnt_q + REF_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ref_cnt_q <= '0;
      refresh_q <= 1'b0;
    end else begin
      ref_cnt_q <= ref_cnt_d;
      refresh_q <= refresh_d;
    end
  end

  assign refresh_req = refresh_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: per-cycle scoreboard against a run-length behavioural model,
// a table of press patterns with hand-derived pulse counts, and reset/refresh sequences.
module tb_button_debouncer;
  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RR = 8;
  localparam int RP = 50;
  localparam int GAP = 12;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] btn_in;
  logic [2:0] btn_state;
  logic [2:0] inc_pulse;
  logic       refresh_req;

  always #5 clk = ~clk;

  button_debouncer #(
    .DIGITS(3), .DB_CYCLES(DB), .REPEAT_EN(1), .REPEAT_DELAY(RD),
    .REPEAT_RATE(RR), .REFRESH_PERIOD(RP)
  ) dut (
    .clk(clk), .reset(reset), .btn_in(btn_in), .btn_state(btn_state),
    .inc_pulse(inc_pulse), .refresh_req(refresh_req)
  );

  typedef struct {
    logic [2:0] st;
    logic [2:0] inc;
    logic       rf;
  } exp_t;

  typedef struct {
    string      name;
    logic [2:0] mask;
    int         hold;
    int         exp_cnt;
    int         exp_first;
  } vec_t;

  exp_t sb_q[$];
  int total = 0;
  int bad = 0;

  // Behavioural model state: input run lengths decide the debounced level,
  // pulses are scheduled from the edge at which the level rose.
  int         m_cyc;
  logic [2:0] m_st;
  logic [2:0] m_val;
  int         m_run[3];
  int         m_rise[3];
  int         m_since;

  logic [2:0] obs_st, obs_inc;
  logic       obs_rf;

  function automatic logic pulse_due(input int d);
    return (d == 0) || (d == RD) || ((d > RD) && (((d - RD) % RR) == 0));
  endfunction

  task automatic check(input string nm, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  task automatic step(input logic rst, input logic [2:0] b);
    exp_t e;
    exp_t w;
    reset  = rst;
    btn_in = b;
    e.st = 3'b000; e.inc = 3'b000; e.rf = 1'b0;
    if (rst) begin
      m_cyc = 0; m_st = 3'b000; m_val = 3'b000; m_since = 0;
      for (int i = 0; i < 3; i++) begin
        m_run[i] = 0; m_rise[i] = 0;
      end
    end else begin
      m_cyc++;
      for (int i = 0; i < 3; i++)
        e.inc[i] = m_st[i] && pulse_due(m_cyc - m_rise[i] - 1);
      for (int i = 0; i < 3; i++) begin
        if (b[i] == m_val[i]) m_run[i]++;
        else begin
          m_val[i] = b[i];
          m_run[i] = 1;
        end
        if (m_run[i] >= DB && m_val[i] != m_st[i]) begin
          m_st[i] = m_val[i];
          if (m_st[i]) m_rise[i] = m_cyc;
        end
      end
      e.st = m_st;
      m_since++;
      e.rf = (|e.inc) || (m_since == RP);
      if (e.rf) m_since = 0;
    end
    sb_q.push_back(e);
    @(negedge clk);
    w = sb_q.pop_front();
    obs_st = btn_state; obs_inc = inc_pulse; obs_rf = refresh_req;
    total++;
    if (obs_st !== w.st || obs_inc !== w.inc || obs_rf !== w.rf) begin
      bad++;
      $display("FAIL cycle %0d rst=%b: st got %b want %b, inc got %b want %b, rf got %b want %b",
               m_cyc, rst, obs_st, w.st, obs_inc, w.inc, obs_rf, w.rf);
    end
  endtask

  vec_t vec[8];
  int cnt[3];
  int first, nfull, other, nref, nbad;

  initial begin
    vec[0] = '{"press0",   3'b001,  5, 1, 5};
    vec[1] = '{"glitch1",  3'b010,  3, 0, 0};
    vec[2] = '{"hold2",    3'b100, 60, 6, 5};
    vec[3] = '{"all",      3'b111,  5, 1, 5};
    vec[4] = '{"min1",     3'b010,  4, 1, 5};
    vec[5] = '{"rel_tc",   3'b001, 20, 1, 5};
    vec[6] = '{"tc_ok",    3'b001, 21, 2, 5};
    vec[7] = '{"hold0_30", 3'b001, 30, 3, 5};

    // Reset, then idle: periodic refresh only.
    step(1'b1, 3'b000);
    step(1'b1, 3'b000);
    check("reset_outputs", int'({obs_st, obs_inc, obs_rf}), 0);
    nref = 0; first = 0;
    for (int j = 1; j <= 200; j++) begin
      step(1'b0, 3'b000);
      if (obs_rf) begin
        nref++;
        if (first == 0) first = j;
      end
    end
    check("idle_first_refresh", first, 50);
    check("idle_refresh_count", nref, 4);
    $display("seq idle: refreshes=%0d first=%0d", nref, first);

    for (int r = 0; r < 8; r++) begin
      for (int l = 0; l < 3; l++) cnt[l] = 0;
      first = 0; nfull = 0; other = 0;
      for (int j = 1; j <= vec[r].hold + GAP; j++) begin
        step(1'b0, (j <= vec[r].hold) ? vec[r].mask : 3'b000);
        for (int l = 0; l < 3; l++)
          if (obs_inc[l]) begin
            if (vec[r].mask[l]) cnt[l]++;
            else other++;
          end
        if (obs_inc != 3'b000 && first == 0) first = j;
        if (obs_inc == vec[r].mask) nfull++;
      end
      for (int l = 0; l < 3; l++)
        if (vec[r].mask[l]) check({vec[r].name, "_lane_count"}, cnt[l], vec[r].exp_cnt);
      check({vec[r].name, "_first_pulse"}, first, vec[r].exp_first);
      check({vec[r].name, "_joint_pulses"}, nfull, vec[r].exp_cnt);
      check({vec[r].name, "_other_lanes"}, other, 0);
      $display("vec %s: mask=%b hold=%0d pulses=%0d/%0d/%0d first=%0d",
               vec[r].name, vec[r].mask, vec[r].hold, cnt[0], cnt[1], cnt[2], first);
    end

    // Button held in REPEAT through a 2-cycle reset counts as a fresh press.
    for (int j = 1; j <= 40; j++) step(1'b0, 3'b001);
    nbad = 0;
    for (int j = 0; j < 2; j++) begin
      step(1'b1, 3'b001);
      if (obs_st != 3'b000 || obs_inc != 3'b000 || obs_rf) nbad++;
    end
    check("reset_hold_outputs_zero", nbad, 0);
    first = 0;
    for (int j = 1; j <= 30; j++) begin
      step(1'b0, 3'b001);
      if (obs_inc[0] && first == 0) first = j;
    end
    check("reset_hold_new_press", first, 5);
    for (int j = 1; j <= GAP; j++) step(1'b0, 3'b000);
    $display("seq reset_hold: first pulse after reset at %0d", first);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Debounce and edge-detect stage. Sits between the button synchronizer and the per-digit counters/serial display driver.
- Takes the synchronized, active-high per-digit button lines and produces clean debounced levels.
- Emits one-cycle increment pulses per digit, with optional auto-repeat while a button is held.
- Emits a display refresh request pulse on any increment and periodically otherwise.

Parameters:
- DIGITS, 3, number of button lanes / counter digits
- DB_CYCLES, 10000, consecutive mismatched samples required to accept a level change (10 ms at 1 MHz); must be >= 2
- REPEAT_EN, 1, 1 = auto-repeat while held, 0 = one pulse per press
- REPEAT_DELAY, 500000, cycles from the press pulse to the first repeat pulse; must be >= 2
- REPEAT_RATE, 100000, cycles between subsequent repeat pulses; must be >= 2
- REFRESH_PERIOD, 50000, maximum cycles between refresh_req pulses; must be >= 2

Ports:
- clk, input, 1, system clock (1 MHz nominal)
- reset, input, 1, synchronous, active-high reset
- btn_in, input, DIGITS, synchronized button levels, active high (1 = pressed)
- btn_state, output, DIGITS, debounced button levels
- inc_pulse, output, DIGITS, one-cycle increment strobe per lane
- refresh_req, output, 1, one-cycle display refresh strobe

Behaviour:
- Clock and reset: single clock, clk. reset is synchronous and active-high. While reset is sampled high, on each edge:
  - btn_state, inc_pulse and refresh_req clear to 0.
  - All counters clear to 0.
  - All lane FSMs go to RELEASED.
- Counter widths: each counter is sized with $clog2 of its limit. No counter ever wraps past its limit.
- Debounce (per lane i):
  - db_cnt[i] clears whenever btn_in[i] == btn_state[i]; otherwise it increments.
  - On the edge where db_cnt[i] == DB_CYCLES-1 and the mismatch is still present, btn_state[i] toggles and db_cnt[i] clears.
  - Net effect: btn_state[i] follows btn_in[i] after exactly DB_CYCLES consecutive mismatched samples. Any glitch shorter than that is discarded.
- Lane FSM (per lane, states RELEASED / DELAY / REPEAT):
  - RELEASED: on a btn_state[i] 0->1 transition, register inc_pulse[i]=1 (high the cycle after btn_state rises), clear rpt_cnt[i], go to DELAY if REPEAT_EN, else to REPEAT with repeat disabled (hold state only).
  - DELAY: rpt_cnt[i] increments. When rpt_cnt[i] == REPEAT_DELAY-1: pulse inc_pulse[i], clear rpt_cnt[i], go to REPEAT.
  - REPEAT: if REPEAT_EN, rpt_cnt[i] increments. When rpt_cnt[i] == REPEAT_RATE-1: pulse inc_pulse[i] and clear rpt_cnt[i].
  - Any state: btn_state[i]==0 means go to RELEASED and clear rpt_cnt[i]. No pulse on release. This takes priority over a coincident repeat terminal count.
- Pulse properties:
  - inc_pulse[i] is never high two consecutive cycles.
  - Lanes are fully independent; simultaneous pulses on several lanes are allowed and all are reported.
- Refresh:
  - refresh_req is registered and high for one cycle when either:
    - any inc_pulse bit is high in the same cycle, or
    - ref_cnt == REFRESH_PERIOD-1.
  - ref_cnt clears on every refresh_req and otherwise increments.
  - Coincident causes produce a single pulse.
- Reset mid-operation: a button held through reset is treated as a new press. btn_state rises DB_CYCLES cycles after reset deasserts, followed by a fresh inc_pulse.
- Latency: first high sample of a clean press on edge k gives btn_state high after edge k+DB_CYCLES-1 and inc_pulse high after edge k+DB_CYCLES.

Test Plan:
Bench parameters: DB_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=8, REFRESH_PERIOD=50.
1. Clean press on btn_in[0] at cycle 10, held 5 cycles -> btn_state[0] high from cycle 13; a single inc_pulse[0] and refresh_req at cycle 14; no repeat; btn_state[0] low 4 cycles after release.
2. 3-cycle glitch on btn_in[1] -> btn_state, inc_pulse and refresh_req stay 0 (apart from the periodic refresh).
3. btn_in[2] held 60 cycles, REPEAT_EN=1 -> inc_pulse[2] at press+4, then +20, then every 8 cycles until release; the pulse count matches exactly.
4. All three lanes pressed on the same cycle -> inc_pulse=3'b111 for one cycle and exactly one refresh_req.
5. Idle inputs for 200 cycles after reset -> refresh_req every 50 cycles, first at cycle 50.
6. reset asserted for 2 cycles while btn_in[0] held in REPEAT -> outputs 0 during reset; new inc_pulse[0] 5 cycles after reset deasserts.
